cpu_writeback: RTL
==================

Name: cpu_writeback

Overview:
- Stage-3a consumer of the CPU pipeline. Takes the execute stage's registered outputs and retires each instruction.
- Owns the data stack: applies pops, then pushes, in one cycle.
- Serves the two combinational stack read ports used by the execute stage.
- Resolves branches, producing the registered kill_4a and the redirect PC for fetch.

Parameters:
- DEPTH, 1024: stack entries. Power of two, at most 1024.
- PTR_W, 11: stack-pointer width. Holds 0..DEPTH.

Ports:
- clk  in  1  pipeline clock
- rst_b  in  1  synchronous, active-high reset (1 = reset, sampled on posedge clk)
- alu__cond_3a  in  1  branch condition
- alu__out_3a  in  32  ALU result / branch target
- c__branch_3a  in  2  branch kind
- c__to_push_3a  in  3  push selector
- st__to_pop_3a  in  11  entries to pop
- r0_3a  in  35  saved top-0 entry (3-bit tag + 32 data)
- r1_3a  in  35  saved top-n entry
- pc_3a  in  32  PC of retiring instruction (debug only)
- st__rd_n_2a  in  11  depth index for the second read port
- st__top_0_2a  out  35  entry at top of stack
- st__top_n_2a  out  35  entry at depth st__rd_n_2a below top
- kill_4a  out  1  squash shadow instructions
- pc_redirect_4a  out  32  new fetch PC, valid while kill_4a=1
- st__depth_4a  out  11  current stack pointer
- st__overflow  out  1  sticky: push attempted while full
- st__underflow  out  1  sticky: pop exceeded depth

Behaviour:
- Reset: sp=0; kill_4a=0; pc_redirect_4a=0; both sticky flags=0. Stack contents are not cleared.
- Squash: while kill_4a=1, the cycle's 3a inputs are ignored (no pop, no push, no branch). The execute stage clears the next slot itself, so the two branch-shadow slots are covered.
- Per unsquashed cycle: (1) pop, (2) push, (3) branch evaluation. All are committed at the same posedge.
- Pop: sp' = sp - to_pop.
  - If to_pop > sp: sp' = 0 and st__underflow is set.
- Push selector c__to_push_3a:
  - 0 none
  - 1 {3'b000, alu__out_3a}
  - 2 r0
  - 3 r1
  - 4 r0 then r1 (r1 ends on top)
  - 5 r1 then r0 (r0 ends on top)
  - 6 r0 then alu value (alu ends on top)
  - 7 reserved, treated as none
- Push overflow: each push is written at index sp'. A push finding sp' = DEPTH is dropped and sets st__overflow. For two-entry pushes with one slot free, the first entry is kept and the second dropped.
- Pops and pushes in the same cycle are legal. Pushes overwrite the popped slots.
- Branch kinds c__branch_3a:
  - 0 none
  - 1 always
  - 2 taken if alu__cond_3a=1
  - 3 taken if alu__cond_3a=0
- Taken branch, next cycle: kill_4a=1 and pc_redirect_4a=alu__out_3a.
- Not taken, or squashed: kill_4a=0 next cycle. pc_redirect_4a holds its last value.
- Back-to-back branches: a branch arriving while kill_4a=1 is squashed. kill_4a therefore never stays high for two consecutive cycles.
- Read ports are combinational from registered state; there is no write bypass.
  - st__top_0_2a = stack[sp-1], or 0 when sp=0.
  - st__top_n_2a = stack[sp-1-n], or 0 when n >= sp.
- Reset mid-operation: sp clears on that edge and all 3a inputs in the reset cycle are discarded.

Decomposition:
- Shared package opcode.vh gains UC_PUSH_* (0..7) and UC_BR_NONE/ALWAYS/IFT/IFF (0..3), next to the existing UC_LEFT_* and UC_RIGHT_* constants.
- One sub-module, cpu_stack_ram:
  - DEPTH x 35 storage
  - two write ports (index, data, enable)
  - two asynchronous read ports
- cpu_writeback holds the pointer arithmetic, squash logic and branch logic.

Test Plan:
- Reset, then push ALU 0x11, 0x22, 0x33 (to_push=1) -> depth=3; top_0 data=0x33; rd_n=2 gives top_n data=0x11.
- Pop 2 and push r0=35'h4_0000_00AA in one cycle -> depth=2; top_0=35'h4_0000_00AA; rd_n=1 gives 0x11.
- Branch kind 2 with cond=1, alu_out=0x100, followed by an instruction pushing 0x55 -> kill_4a=1 and pc_redirect_4a=0x100 for exactly one cycle; the push of 0x55 is squashed and depth is unchanged.
- Branch kind 3 with cond=1 -> kill_4a stays 0.
- With depth=1, pop 5 -> depth=0, st__underflow=1, top_0=0. Pushing 1023 then to_push=4 -> depth=1024, st__overflow=1, top_0=r0.
- Assert rst_b for one cycle during a push -> depth=0, kill_4a=0, both flags 0. Reset with to_push=1 held at input -> no push occurs in the reset cycle.

Source files
------------

// File: rtl/cpu_writeback_pkg.sv
// Shared constants for the writeback stage: push selectors, branch kinds, stack entry type.
package cpu_writeback_pkg;

    localparam int ENTRY_W = 35;
    typedef logic [ENTRY_W-1:0] entry_t;

    localparam logic [2:0] UC_PUSH_NONE   = 3'd0;
    localparam logic [2:0] UC_PUSH_ALU    = 3'd1;
    localparam logic [2:0] UC_PUSH_R0     = 3'd2;
    localparam logic [2:0] UC_PUSH_R1     = 3'd3;
    localparam logic [2:0] UC_PUSH_R0_R1  = 3'd4;
    localparam logic [2:0] UC_PUSH_R1_R0  = 3'd5;
    localparam logic [2:0] UC_PUSH_R0_ALU = 3'd6;
    localparam logic [2:0] UC_PUSH_RSVD   = 3'd7;

    localparam logic [1:0] UC_BR_NONE   = 2'd0;
    localparam logic [1:0] UC_BR_ALWAYS = 2'd1;
    localparam logic [1:0] UC_BR_IFT    = 2'd2;
    localparam logic [1:0] UC_BR_IFF    = 2'd3;

    function automatic entry_t alu_entry(input logic [31:0] v);
        return {3'b000, v};
    endfunction

endpackage

// File: rtl/cpu_stack_ram.sv
// Data-stack storage: two synchronous write ports, two asynchronous read ports, no reset.
module cpu_stack_ram
    import cpu_writeback_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wa_en_i,
    input  logic [IDX_W-1:0] wa_idx_i,
    input  entry_t           wa_data_i,
    input  logic             wb_en_i,
    input  logic [IDX_W-1:0] wb_idx_i,
    input  entry_t           wb_data_i,
    input  logic [IDX_W-1:0] ra_idx_i,
    output entry_t           ra_data_o,
    input  logic [IDX_W-1:0] rb_idx_i,
    output entry_t           rb_data_o
);

    entry_t mem_q [DEPTH];

    // The two write indices are always consecutive slots, so they never collide.
    always_ff @(posedge clk) begin
        if (wa_en_i) mem_q[wa_idx_i] <= wa_data_i;
        if (wb_en_i) mem_q[wb_idx_i] <= wb_data_i;
    end

    assign ra_data_o = mem_q[ra_idx_i];
    assign rb_data_o = mem_q[rb_idx_i];

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: stack pointer update (pop then push), sticky stack errors, branch resolution.
module cpu_writeback
    import cpu_writeback_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int PTR_W = 11
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             alu__cond_3a,
    input  logic [31:0]      alu__out_3a,
    input  logic [1:0]       c__branch_3a,
    input  logic [2:0]       c__to_push_3a,
    input  logic [PTR_W-1:0] st__to_pop_3a,
    input  entry_t           r0_3a,
    input  entry_t           r1_3a,
    input  logic [31:0]      pc_3a,
    input  logic [PTR_W-1:0] st__rd_n_2a,
    output entry_t           st__top_0_2a,
    output entry_t           st__top_n_2a,
    output logic             kill_4a,
    output logic [31:0]      pc_redirect_4a,
    output logic [PTR_W-1:0] st__depth_4a,
    output logic             st__overflow,
    output logic             st__underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] sp_q, sp_d;
    logic             kill_q, kill_d;
    logic [31:0]      redirect_q, redirect_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             active;
    logic [PTR_W-1:0] pop_amt;
    logic [PTR_W-1:0] sp_pop, sp_pop_p1;
    logic [1:0]       n_push;
    entry_t           e0, e1;
    logic             wa_en, wb_en;
    logic             taken;

    logic [PTR_W-1:0] rd0_full, rdn_full;
    entry_t           ra_data, rb_data;

    always_comb begin
        active     = ~kill_q;
        pop_amt    = active ? st__to_pop_3a : '0;
        unf_d      = unf_q;
        if (pop_amt > sp_q) begin
            sp_pop = '0;
            unf_d  = 1'b1;
        end else begin
            sp_pop = sp_q - pop_amt;
        end
        sp_pop_p1 = sp_pop + PTR_W'(1);

        n_push = 2'd0;
        e0     = '0;
        e1     = '0;
        if (active) begin
            case (c__to_push_3a)
                UC_PUSH_ALU:    begin n_push = 2'd1; e0 = alu_entry(alu__out_3a); end
                UC_PUSH_R0:     begin n_push = 2'd1; e0 = r0_3a; end
                UC_PUSH_R1:     begin n_push = 2'd1; e0 = r1_3a; end
                UC_PUSH_R0_R1:  begin n_push = 2'd2; e0 = r0_3a; e1 = r1_3a; end
                UC_PUSH_R1_R0:  begin n_push = 2'd2; e0 = r1_3a; e1 = r0_3a; end
                UC_PUSH_R0_ALU: begin n_push = 2'd2; e0 = r0_3a; e1 = alu_entry(alu__out_3a); end
                default:        n_push = 2'd0;
            endcase
        end

        // A push landing at or beyond DEPTH is dropped; the first of a pair may still fit.
        wa_en = (n_push != 2'd0) && (sp_pop < DEPTH_P);
        wb_en = (n_push == 2'd2) && (sp_pop_p1 < DEPTH_P);
        ovf_d = ovf_q | ((n_push != 2'd0) && !wa_en) | ((n_push == 2'd2) && !wb_en);
        sp_d  = sp_pop + PTR_W'(wa_en) + PTR_W'(wb_en);

        taken = 1'b0;
        if (active) begin
            case (c__branch_3a)
                UC_BR_ALWAYS: taken = 1'b1;
                UC_BR_IFT:    taken = alu__cond_3a;
                UC_BR_IFF:    taken = ~alu__cond_3a;
                default:      taken = 1'b0;
            endcase
        end
        kill_d     = taken;
        redirect_d = taken ? alu__out_3a : redirect_q;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            sp_q       <= '0;
            kill_q     <= 1'b0;
            redirect_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            kill_q     <= kill_d;
            redirect_q <= redirect_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd0_full = sp_q - PTR_W'(1);
    assign rdn_full = sp_q - PTR_W'(1) - st__rd_n_2a;

    cpu_stack_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk       (clk),
        .wa_en_i   (wa_en & ~rst_b),
        .wa_idx_i  (sp_pop[IDX_W-1:0]),
        .wa_data_i (e0),
        .wb_en_i   (wb_en & ~rst_b),
        .wb_idx_i  (sp_pop_p1[IDX_W-1:0]),
        .wb_data_i (e1),
        .ra_idx_i  (rd0_full[IDX_W-1:0]),
        .ra_data_o (ra_data),
        .rb_idx_i  (rdn_full[IDX_W-1:0]),
        .rb_data_o (rb_data)
    );

    assign st__top_0_2a   = (sp_q == '0) ? '0 : ra_data;
    assign st__top_n_2a   = (st__rd_n_2a >= sp_q) ? '0 : rb_data;
    assign kill_4a        = kill_q;
    assign pc_redirect_4a = redirect_q;
    assign st__depth_4a   = sp_q;
    assign st__overflow   = ovf_q;
    assign st__underflow  = unf_q;

    // pc_3a is carried for debug visibility only; the high index bits are out of range by construction.
    logic unused_ok;
    assign unused_ok = ^{pc_3a, sp_pop[PTR_W-1:IDX_W], sp_pop_p1[PTR_W-1:IDX_W],
                         rd0_full[PTR_W-1:IDX_W], rdn_full[PTR_W-1:IDX_W]};

endmodule
